aes_round_sequencer: RTL and testbench
======================================

# aes_round_sequencer

Round scheduler for the iterative AES-128 encryption datapath (SubBytes, ShiftRows, MixColumns and AddRoundKeys sharing one state register). It accepts key-load and data-block requests from the top-level controller and sequences the key expander and the round datapath. It generates the round index, the per-round enables and the final-round MixColumns bypass. It presents the finished block to the TX shift register through a valid/ready handshake.

## Interface
Parameters:
- NUM_ROUNDS, 10, number of cipher rounds. Legal values are 10, 12 and 14.
- ROUND_W, 4, width of the round index.

Ports:
- clk  in  1  system clock. All logic is on the rising edge.
- n_rst  in  1  reset. Synchronous and active-low.
- start  in  1  request strobe. Sampled only in IDLE.
- data_type  in  1  request type, sampled with start. 0 = data block, 1 = new key.
- key_ready  in  1  key expander has the round key for cur_round available.
- out_ready  in  1  TX shift register accepts the result.
- ready  out  1  high in IDLE only.
- load_key  out  1  one-cycle pulse. The key expander captures the received key.
- load_data  out  1  one-cycle pulse. The datapath captures data_initial XOR round key 0.
- round_en  out  1  the datapath advances one full round this cycle.
- mix_bypass  out  1  MixColumns is skipped. High during the final round only.
- cur_round  out  ROUND_W  round index driven to the key expander.
- out_valid  out  1  result is valid and held stable.
- done_chg_key  out  1  one-cycle pulse when the key change completes.
- err  out  1  one-cycle pulse when a data request is made with no key loaded.

## Operation
- FSM states are IDLE, KEYLD, KEYWAIT, LOAD, ROUND and OUT. All outputs are decoded from the state and the registered counters (Moore), except round_en.
- key_loaded is an internal flag. It is cleared by reset and set when KEYWAIT exits.
- IDLE:
  - start=1 with data_type=1 goes to KEYLD.
  - start=1 with data_type=0 and key_loaded=1 goes to LOAD.
  - start=1 with data_type=0 and key_loaded=0 stays in IDLE and pulses err for the next cycle.
- KEYLD: load_key=1 and cur_round=0. Goes to KEYWAIT unconditionally.
- KEYWAIT: waits for key_ready=1. Then it sets key_loaded, pulses done_chg_key for one cycle and returns to IDLE.
- LOAD: load_data=1 and cur_round=0.
  - If key_ready=1, goes to ROUND with cur_round=1.
  - Otherwise stays in LOAD with load_data held high.
- ROUND: round_en = key_ready.
  - On each edge with round_en=1, cur_round increments.
  - On the edge where cur_round=NUM_ROUNDS and round_en=1, goes to OUT.
  - key_ready=0 stalls the round: round_en=0 and cur_round is held.
  - mix_bypass = (cur_round==NUM_ROUNDS).
- OUT: out_valid=1 and cur_round holds NUM_ROUNDS. Returns to IDLE on out_ready=1. out_ready outside OUT is ignored.
- start outside IDLE is ignored and no request is queued.
- A key change while a block is in flight is impossible, because requests are accepted only in IDLE.
- cur_round never exceeds NUM_ROUNDS and never wraps.

## Timing
- Reset:
  - n_rst=0 at an edge forces IDLE and clears key_loaded and cur_round.
  - All outputs are 0, except ready=1.
  - Reset in any state, including mid-round, aborts the operation with no out_valid and no done_chg_key.
- Data latency with key_ready held at 1:
  - start is sampled at edge E0.
  - LOAD occupies cycle 1.
  - ROUND occupies cycles 2 through NUM_ROUNDS+1, with cur_round 1..NUM_ROUNDS.
  - out_valid rises in cycle NUM_ROUNDS+2, which is 12 for AES-128.
- Each stall cycle (key_ready=0) adds one cycle of latency.
- Key-change latency:
  - KEYLD is cycle 1 and KEYWAIT starts in cycle 2.
  - done_chg_key is high in the cycle after the edge where key_ready was sampled high in KEYWAIT.
- OUT to IDLE: ready=1 in the cycle after out_ready is sampled. The next start can be accepted at that edge. Minimum request spacing is NUM_ROUNDS+3 cycles.
- err and done_chg_key are always exactly one cycle wide.

## Test plan
- Reset, then a data request with no key loaded: err pulses for 1 cycle, ready stays 1, load_data never rises.
- Key load with key_ready rising 3 cycles after load_key: load_key is 1 cycle, done_chg_key pulses once, then ready=1.
- Data block with key_ready=1 and out_ready=1:
  - load_data in cycle 1.
  - round_en high in cycles 2–11 with cur_round 1..10.
  - mix_bypass high only in cycle 11.
  - out_valid in cycle 12 for exactly 1 cycle.
- Stall: drop key_ready for 2 cycles during round 5. cur_round holds 5 with round_en=0, and out_valid arrives in cycle 14.
- Backpressure and ignored requests: out_ready=0 for 4 cycles holds out_valid and cur_round=10. start pulses during ROUND and OUT are ignored.
- Reset mid-operation: n_rst=0 while cur_round=6. IDLE follows, all outputs are at reset values, and a subsequent data request raises err because key_loaded was cleared.

Source files
------------

// File: rtl/aes_round_sequencer.sv
// Round scheduler for the iterative AES datapath: accepts key/data requests,
// steps the round index and key expander, and hands the result to TX.
module aes_round_sequencer #(
   parameter int NUM_ROUNDS = 10,
   parameter int ROUND_W    = 4
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               start,
   input  logic               data_type,
   input  logic               key_ready,
   input  logic               out_ready,
   output logic               ready,
   output logic               load_key,
   output logic               load_data,
   output logic               round_en,
   output logic               mix_bypass,
   output logic [ROUND_W-1:0] cur_round,
   output logic               out_valid,
   output logic               done_chg_key,
   output logic               err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_KEYLD,
      S_KEYWAIT,
      S_LOAD,
      S_ROUND,
      S_OUT
   } state_t;

   localparam logic [ROUND_W-1:0] LAST_ROUND  = ROUND_W'(NUM_ROUNDS);
   localparam logic [ROUND_W-1:0] FIRST_ROUND = ROUND_W'(1);

   state_t               state_q, state_d;
   logic                 key_loaded_q, key_loaded_d;
   logic [ROUND_W-1:0]   cur_round_q, cur_round_d;
   logic                 ready_q, ready_d;
   logic                 load_key_q, load_key_d;
   logic                 load_data_q, load_data_d;
   logic                 mix_bypass_q, mix_bypass_d;
   logic                 out_valid_q, out_valid_d;
   logic                 done_chg_key_q, done_chg_key_d;
   logic                 err_q, err_d;

   // Next-state, round counter and the two event pulses.
   always_comb begin
      state_d        = state_q;
      key_loaded_d   = key_loaded_q;
      cur_round_d    = cur_round_q;
      err_d          = 1'b0;
      done_chg_key_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            cur_round_d = '0;
            if (start) begin
               if (data_type) begin
                  state_d = S_KEYLD;
               end else if (key_loaded_q) begin
                  state_d = S_LOAD;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_KEYLD: begin
            cur_round_d = '0;
            state_d     = S_KEYWAIT;
         end
         S_KEYWAIT: begin
            if (key_ready) begin
               state_d        = S_IDLE;
               key_loaded_d   = 1'b1;
               done_chg_key_d = 1'b1;
            end
         end
         S_LOAD: begin
            cur_round_d = '0;
            if (key_ready) begin
               state_d     = S_ROUND;
               cur_round_d = FIRST_ROUND;
            end
         end
         S_ROUND: begin
            // The final round leaves the index parked at NUM_ROUNDS for OUT.
            if (key_ready) begin
               if (cur_round_q == LAST_ROUND) begin
                  state_d = S_OUT;
               end else begin
                  cur_round_d = cur_round_q + FIRST_ROUND;
               end
            end
         end
         S_OUT: begin
            if (out_ready) begin
               state_d     = S_IDLE;
               cur_round_d = '0;
            end
         end
         default: begin
            state_d     = S_IDLE;
            cur_round_d = '0;
         end
      endcase
   end

   // Moore outputs are decoded from the next state so they register in step.
   always_comb begin
      ready_d      = (state_d == S_IDLE);
      load_key_d   = (state_d == S_KEYLD);
      load_data_d  = (state_d == S_LOAD);
      out_valid_d  = (state_d == S_OUT);
      mix_bypass_d = (state_d == S_ROUND) && (cur_round_d == LAST_ROUND);
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q        <= S_IDLE;
         key_loaded_q   <= 1'b0;
         cur_round_q    <= '0;
         ready_q        <= 1'b1;
         load_key_q     <= 1'b0;
         load_data_q    <= 1'b0;
         mix_bypass_q   <= 1'b0;
         out_valid_q    <= 1'b0;
         done_chg_key_q <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         key_loaded_q   <= key_loaded_d;
         cur_round_q    <= cur_round_d;
         ready_q        <= ready_d;
         load_key_q     <= load_key_d;
         load_data_q    <= load_data_d;
         mix_bypass_q   <= mix_bypass_d;
         out_valid_q    <= out_valid_d;
         done_chg_key_q <= done_chg_key_d;
         err_q          <= err_d;
      end
   end

   // round_en follows key_ready directly so a late round key stalls the same cycle.
   assign round_en     = (state_q == S_ROUND) && key_ready;
   assign ready        = ready_q;
   assign load_key     = load_key_q;
   assign load_data    = load_data_q;
   assign mix_bypass   = mix_bypass_q;
   assign cur_round    = cur_round_q;
   assign out_valid    = out_valid_q;
   assign done_chg_key = done_chg_key_q;
   assign err          = err_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: directed test-plan steps plus
// randomized request traffic checked against a round-count reference model.
module tb_aes_round_sequencer;

   localparam int N  = 10;
   localparam int RW = 4;

   logic          clk = 1'b0;
   logic          n_rst, start, data_type, key_ready, out_ready;
   logic          ready, load_key, load_data, round_en, mix_bypass;
   logic          out_valid, done_chg_key, err;
   logic [RW-1:0] cur_round;

   int  checks = 0;
   int  errors = 0;
   bit  model_key_loaded = 1'b0;

   always #5 clk = ~clk;

   aes_round_sequencer #(.NUM_ROUNDS(N), .ROUND_W(RW)) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .start        (start),
      .data_type    (data_type),
      .key_ready    (key_ready),
      .out_ready    (out_ready),
      .ready        (ready),
      .load_key     (load_key),
      .load_data    (load_data),
      .round_en     (round_en),
      .mix_bypass   (mix_bypass),
      .cur_round    (cur_round),
      .out_valid    (out_valid),
      .done_chg_key (done_chg_key),
      .err          (err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // e_cr < 0 means the round index is not defined in that cycle.
   task automatic chk_all(input string tag, input bit e_rdy, input bit e_lk, input bit e_ld,
                          input bit e_re, input bit e_mb, input bit e_ov, input bit e_dn,
                          input bit e_err, input int e_cr);
      chk({tag, ".ready"},        32'(ready),        32'(e_rdy));
      chk({tag, ".load_key"},     32'(load_key),     32'(e_lk));
      chk({tag, ".load_data"},    32'(load_data),    32'(e_ld));
      chk({tag, ".round_en"},     32'(round_en),     32'(e_re));
      chk({tag, ".mix_bypass"},   32'(mix_bypass),   32'(e_mb));
      chk({tag, ".out_valid"},    32'(out_valid),    32'(e_ov));
      chk({tag, ".done_chg_key"}, 32'(done_chg_key), 32'(e_dn));
      chk({tag, ".err"},          32'(err),          32'(e_err));
      if (e_cr >= 0) chk({tag, ".cur_round"}, 32'(cur_round), 32'(e_cr));
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         start = 1'b0;
         data_type = 1'($urandom_range(0, 1));
         key_ready = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk_all($sformatf("%s.idle%0d", tag, i), 1, 0, 0, 0, 0, 0, 0, 0, -1);
         next_cycle();
      end
   endtask

   // Data request with no key: a single err pulse, nothing else moves.
   task automatic run_err(input string tag);
      start = 1'b1; data_type = 1'b0; key_ready = 1'b1;
      @(negedge clk);
      chk_all({tag, ".req"}, 1, 0, 0, 0, 0, 0, 0, 0, -1);
      next_cycle();
      start = 1'b0;
      @(negedge clk);
      chk_all({tag, ".pulse"}, 1, 0, 0, 0, 0, 0, 0, 1, -1);
      next_cycle();
      @(negedge clk);
      chk_all({tag, ".after"}, 1, 0, 0, 0, 0, 0, 0, 0, -1);
      next_cycle();
      $display("txn %s: err request, key_loaded=%0d", tag, model_key_loaded);
   endtask

   // Key load: key_ready stays low for wait_cycles KEYWAIT cycles, then high.
   task automatic run_key(input string tag, input int wait_cycles);
      start = 1'b1; data_type = 1'b1; key_ready = 1'b0;
      @(negedge clk);
      chk_all({tag, ".req"}, 1, 0, 0, 0, 0, 0, 0, 0, -1);
      next_cycle();
      start = 1'b0;
      key_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk_all({tag, ".keyld"}, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      next_cycle();
      for (int w = 0; w <= wait_cycles; w++) begin
         key_ready = (w == wait_cycles);
         start = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk_all($sformatf("%s.wait%0d", tag, w), 0, 0, 0, 0, 0, 0, 0, 0, -1);
         next_cycle();
      end
      start = 1'b0;
      key_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk_all({tag, ".done"}, 1, 0, 0, 0, 0, 0, 1, 0, -1);
      next_cycle();
      @(negedge clk);
      chk_all({tag, ".after"}, 1, 0, 0, 0, 0, 0, 0, 0, -1);
      next_cycle();
      model_key_loaded = 1'b1;
      $display("txn %s: key load, wait=%0d", tag, wait_cycles);
   endtask

   // Data block. The model tracks only how many key_ready-high cycles have
   // been accepted: 0 means loading, 1..N is the round number, above N is output.
   task automatic run_data(input string tag, input int stall_pct, input int bp_cycles,
                           input int stall_round, input int stall_len, input int abort_round);
      int  pos = 0;
      int  cyc = 0;
      int  stalls = 0;
      int  bp = 0;
      int  sl = 0;
      int  out_cycle = 0;
      bit  fin = 1'b0;
      bit  aborted = 1'b0;
      bit  in_out;
      start = 1'b1; data_type = 1'b0; key_ready = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk_all({tag, ".req"}, 1, 0, 0, 0, 0, 0, 0, 0, -1);
      next_cycle();
      while (!fin && cyc < 400) begin
         cyc++;
         start = 1'($urandom_range(0, 1));
         data_type = 1'($urandom_range(0, 1));
         if (pos == stall_round && sl < stall_len) begin
            key_ready = 1'b0;
            sl++;
         end else begin
            key_ready = ($urandom_range(0, 99) >= stall_pct);
         end
         in_out = (pos > N);
         out_ready = in_out ? (bp >= bp_cycles) : 1'($urandom_range(0, 1));
         if (abort_round > 0 && pos == abort_round) n_rst = 1'b0;
         @(negedge clk);
         chk_all($sformatf("%s.c%0d", tag, cyc), 0, 0, (pos == 0), (pos >= 1 && pos <= N && key_ready),
                 (pos == N), in_out, 0, 0, in_out ? N : pos);
         if (in_out && out_cycle == 0) begin
            out_cycle = cyc;
            chk({tag, ".latency"}, 32'(cyc), 32'(N + 2 + stalls));
         end
         next_cycle();
         if (!n_rst) begin
            n_rst = 1'b1;
            aborted = 1'b1;
            fin = 1'b1;
            model_key_loaded = 1'b0;
         end else if (in_out) begin
            if (out_ready) fin = 1'b1;
            else bp++;
         end else if (key_ready) begin
            pos++;
         end else begin
            stalls++;
         end
      end
      if (!fin) chk({tag, ".timeout"}, 32'(0), 32'(1));
      start = 1'b0;
      key_ready = 1'b0;
      @(negedge clk);
      if (aborted) chk_all({tag, ".reset"}, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      else         chk_all({tag, ".idle"},  1, 0, 0, 0, 0, 0, 0, 0, -1);
      next_cycle();
      $display("txn %s: data block, stalls=%0d backpressure=%0d out_cycle=%0d aborted=%0d",
               tag, stalls, bp, out_cycle, aborted);
   endtask

   initial begin
      n_rst = 1'b0; start = 1'b0; data_type = 1'b0; key_ready = 1'b0; out_ready = 1'b0;
      next_cycle();
      next_cycle();
      @(negedge clk);
      chk_all("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0);
      n_rst = 1'b1;
      next_cycle();

      run_err("no_key");
      run_key("key_load", 2);
      idle_cycles("post_key", 2);
      run_data("plain", 0, 0, -1, 0, 0);
      run_data("stall_r5", 0, 0, 5, 2, 0);
      run_data("backpressure", 0, 4, -1, 0, 0);
      run_data("abort_r6", 0, 0, -1, 0, 6);
      run_err("after_abort");
      run_key("rekey", 0);

      for (int t = 0; t < 25; t++) begin
         case ($urandom_range(0, 3))
            0: run_key($sformatf("rnd%0d_key", t), int'($urandom_range(0, 4)));
            1: idle_cycles($sformatf("rnd%0d", t), int'($urandom_range(1, 3)));
            default: begin
               if (model_key_loaded)
                  run_data($sformatf("rnd%0d_data", t), 30, int'($urandom_range(0, 3)),
                           int'($urandom_range(0, N)), int'($urandom_range(0, 3)),
                           ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, N)) : 0);
               else
                  run_err($sformatf("rnd%0d_err", t));
            end
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
